superresolution_frame_scheduler: RTL and testbench

Frame-level sequencer between the video input stream and the `superresolution` core's slave port. It admits exactly one `Height`×`Width` frame at a time, starting on a start-of-frame marker. It counts the core's output lines until the frame has fully drained, then either idles or re-arms for the next frame. It also validates input line/frame markers and reports status to the control register block.

---
 rtl/superresolution_pkg.sv | 19 +
 rtl/frame_position_counter.sv | 43 ++++
 rtl/superresolution_frame_scheduler.sv | 137 +++++++++++++
 tb/tb_superresolution_frame_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/superresolution_pkg.sv
// Shared types for the superresolution frame scheduler.
package superresolution_pkg;

  localparam int unsigned ChannelWidth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic [ChannelWidth-1:0] red;
    logic [ChannelWidth-1:0] green;
    logic [ChannelWidth-1:0] blue;
  } pixel_t;

endpackage

// File: rtl/frame_position_counter.sv
// Row/column position tracker for a Height x Width raster with end-of-line/frame flags.
module frame_position_counter #(
  parameter int unsigned Height = 1080,
  parameter int unsigned Width  = 1920
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic first_c,
  output logic eol_c,
  output logic eof_c
);

  localparam int unsigned ColWidth = (Width > 1) ? $clog2(Width) : 1;
  localparam int unsigned RowWidth = (Height > 1) ? $clog2(Height) : 1;

  logic [ColWidth-1:0] col;
  logic [RowWidth-1:0] row;

  assign eol_c   = (col == ColWidth'(Width - 1));
  assign eof_c   = eol_c && (row == RowWidth'(Height - 1));
  assign first_c = (col == '0) && (row == '0);

  // Step one position per accepted pixel, wrapping at line and frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (eol_c) begin
        col <= '0;
        row <= eof_c ? '0 : row + RowWidth'(1);
      end else begin
        col <= col + ColWidth'(1);
      end
    end
  end

endmodule

// File: rtl/superresolution_frame_scheduler.sv
// Admits one frame at a time into the superresolution core and tracks its drain.
module superresolution_frame_scheduler
  import superresolution_pkg::*;
#(
  parameter int unsigned Height     = 1080,
  parameter int unsigned Width      = 1920,
  parameter int unsigned OutLines   = 2160,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic                  abort_i,
  input  logic                  up_valid_i,
  output logic                  up_ready_o,
  input  logic [23:0]           up_pixel_i,
  input  logic                  up_sof_i,
  input  logic                  up_eol_i,
  output logic                  sr_valid_o,
  input  logic                  sr_ready_i,
  output logic [7:0]            sr_red_o,
  output logic [7:0]            sr_green_o,
  output logic [7:0]            sr_blue_o,
  input  logic                  mon_valid_i,
  input  logic                  mon_ready_i,
  input  logic                  mon_last_i,
  output logic                  busy_o,
  output logic [CountWidth-1:0] frame_count_o,
  output logic                  error_o,
  input  logic                  error_clear_i
);

  localparam int unsigned LineWidth = $clog2(OutLines + 1);

  frame_state_e         state, state_next;
  pixel_t               pix_in;
  logic [LineWidth-1:0] line_cnt;
  logic                 abort_pend;
  logic                 first_c, eol_c, eof_c;
  logic                 active_c, pix_xfer_c, mon_beat_c, line_inc_c;
  logic                 lines_hit_c, complete_c, rearm_c, err_set_c;

  assign pix_in      = up_pixel_i;
  assign active_c    = (state == FEED) || (state == DRAIN);
  assign pix_xfer_c  = (state == FEED) && up_valid_i && sr_ready_i;
  assign mon_beat_c  = mon_valid_i && mon_ready_i && mon_last_i;
  assign line_inc_c  = mon_beat_c && active_c && (line_cnt != LineWidth'(OutLines));
  assign lines_hit_c = (line_cnt == LineWidth'(OutLines)) ||
                       (mon_beat_c && (line_cnt == LineWidth'(OutLines - 1)));
  assign complete_c  = lines_hit_c && ((state == DRAIN) || (pix_xfer_c && eof_c));
  assign rearm_c     = continuous_i && !abort_pend && !abort_i;
  assign err_set_c   = (mon_beat_c && !active_c) ||
                       (pix_xfer_c && ((up_eol_i != eol_c) || (up_sof_i && !first_c)));

  // Input raster position; held at (0,0) outside FEED so every frame starts clean.
  frame_position_counter #(
    .Height(Height),
    .Width (Width)
  ) u_position (
    .clk    (clock_i),
    .rst_n  (reset_ni),
    .clear  (state != FEED),
    .advance(pix_xfer_c),
    .first_c(first_c),
    .eol_c  (eol_c),
    .eof_c  (eof_c)
  );

  // State register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_next;
  end

  // Next-state logic and the zero-latency pass-through handshake.
  always_comb begin
    state_next = state;
    up_ready_o = 1'b0;
    sr_valid_o = 1'b0;
    sr_red_o   = '0;
    sr_green_o = '0;
    sr_blue_o  = '0;
    case (state)
      IDLE: begin
        if (start_i) state_next = SYNC;
      end
      SYNC: begin
        up_ready_o = !(up_valid_i && up_sof_i);
        if (abort_i)                      state_next = IDLE;
        else if (up_valid_i && up_sof_i)  state_next = FEED;
      end
      FEED: begin
        up_ready_o = sr_ready_i;
        sr_valid_o = up_valid_i;
        sr_red_o   = pix_in.red;
        sr_green_o = pix_in.green;
        sr_blue_o  = pix_in.blue;
        if (complete_c)                 state_next = rearm_c ? SYNC : IDLE;
        else if (pix_xfer_c && eof_c)   state_next = DRAIN;
      end
      DRAIN: begin
        if (complete_c) state_next = rearm_c ? SYNC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output-line counter, restarted each time a frame enters FEED.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)                                line_cnt <= '0;
    else if ((state != FEED) && (state_next == FEED)) line_cnt <= '0;
    else if (line_inc_c)                          line_cnt <= line_cnt + LineWidth'(1);
  end

  // Abort request held until the current frame completes.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)                    abort_pend <= 1'b0;
    else if (state_next == IDLE)      abort_pend <= 1'b0;
    else if (abort_i && active_c)     abort_pend <= 1'b1;
  end

  // Status: busy flag, completed-frame count and sticky error (set beats clear).
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      busy_o        <= 1'b0;
      frame_count_o <= '0;
      error_o       <= 1'b0;
    end else begin
      busy_o <= (state_next != IDLE);
      if (complete_c) frame_count_o <= frame_count_o + CountWidth'(1);
      if (err_set_c)          error_o <= 1'b1;
      else if (error_clear_i) error_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_superresolution_frame_scheduler.sv
// Directed bench for the frame scheduler with a frame-level reference model.
module tb_superresolution_frame_scheduler;

  localparam int unsigned H  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned OL = 8;
  localparam int unsigned CW = 16;
  localparam int M_IDLE = 0, M_SYNC = 1, M_FEED = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, continuous, abort, err_clear;
  logic          up_valid, up_sof, up_eol, sr_ready;
  logic [23:0]   up_pixel;
  logic          mon_valid, mon_ready, mon_last;
  logic          up_ready, sr_valid, busy, error;
  logic [7:0]    sr_red, sr_green, sr_blue;
  logic [CW-1:0] frame_count;

  int errors = 0;
  int checks = 0;
  int fwd = 0;
  int drain_xfer = 0;
  logic [7:0] tag = 8'd0;

  // Reference model: frame phase, next pixel index, lines seen, status.
  int m_mode, m_pix, m_lines, m_count;
  bit m_abort, m_err, m_busy;

  always #5 clk = ~clk;

  superresolution_frame_scheduler #(
    .Height(H), .Width(W), .OutLines(OL), .CountWidth(CW)
  ) dut (
    .clock_i      (clk),
    .reset_ni     (rst_n),
    .start_i      (start),
    .continuous_i (continuous),
    .abort_i      (abort),
    .up_valid_i   (up_valid),
    .up_ready_o   (up_ready),
    .up_pixel_i   (up_pixel),
    .up_sof_i     (up_sof),
    .up_eol_i     (up_eol),
    .sr_valid_o   (sr_valid),
    .sr_ready_i   (sr_ready),
    .sr_red_o     (sr_red),
    .sr_green_o   (sr_green),
    .sr_blue_o    (sr_blue),
    .mon_valid_i  (mon_valid),
    .mon_ready_i  (mon_ready),
    .mon_last_i   (mon_last),
    .busy_o       (busy),
    .frame_count_o(frame_count),
    .error_o      (error),
    .error_clear_i(err_clear)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pix = 0; m_lines = 0; m_count = 0;
    m_abort = 0; m_err = 0; m_busy = 0;
  endtask

  // Advance the model by one clock from the inputs present at the edge.
  task automatic model_step();
    bit xfer, mon, act, nerr, last, done;
    int lines_after, nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    act  = (m_mode == M_FEED) || (m_mode == M_DRAIN);
    xfer = (m_mode == M_FEED) && up_valid && sr_ready;
    mon  = mon_valid && mon_ready && mon_last;
    nerr = mon && !act;
    if (xfer) begin
      if (up_eol != ((m_pix % W) == W - 1)) nerr = 1;
      if (up_sof && m_pix != 0) nerr = 1;
    end
    lines_after = m_lines + ((mon && act && m_lines < OL) ? 1 : 0);
    last = xfer && (m_pix == H * W - 1);
    done = (lines_after >= OL) && ((m_mode == M_DRAIN) || last);
    nxt = m_mode;
    case (m_mode)
      M_IDLE: if (start) nxt = M_SYNC;
      M_SYNC: begin
        if (abort) nxt = M_IDLE;
        else if (up_valid && up_sof) nxt = M_FEED;
      end
      default: begin
        if (done) nxt = (continuous && !m_abort && !abort) ? M_SYNC : M_IDLE;
        else if (last) nxt = M_DRAIN;
      end
    endcase
    if (xfer) m_pix++;
    m_lines = lines_after;
    if (nxt == M_FEED && m_mode != M_FEED) begin
      m_pix = 0;
      m_lines = 0;
    end
    if (nxt == M_IDLE) m_abort = 0;
    else if (abort && act) m_abort = 1;
    m_err = nerr ? 1'b1 : (err_clear ? 1'b0 : m_err);
    if (done) m_count = (m_count + 1) % (1 << CW);
    m_busy = (nxt != M_IDLE);
    m_mode = nxt;
  endtask

  task automatic compare();
    logic exp_ready, exp_valid;
    logic [23:0] exp_pix;
    exp_ready = 1'b0; exp_valid = 1'b0; exp_pix = '0;
    if (m_mode == M_SYNC) begin
      exp_ready = !(up_valid && up_sof);
    end else if (m_mode == M_FEED) begin
      exp_ready = sr_ready;
      exp_valid = up_valid;
      exp_pix   = up_pixel;
    end
    chk("up_ready", 32'(up_ready), 32'(exp_ready));
    chk("sr_valid", 32'(sr_valid), 32'(exp_valid));
    chk("sr_pixel", 32'({sr_red, sr_green, sr_blue}), 32'(exp_pix));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_count", 32'(frame_count), 32'(m_count));
    chk("error", 32'(error), 32'(m_err));
    if (sr_valid && sr_ready) begin
      fwd++;
      if (m_mode == M_DRAIN) drain_xfer++;
      chk("order", 32'({sr_red, sr_green, sr_blue}),
          32'({tag, 8'(m_pix / W), 8'(m_pix % W)}));
    end
  endtask

  task automatic tick(output bit acc);
    @(negedge clk);
    compare();
    acc = up_valid && up_ready;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step();
    bit a;
    tick(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic junk(input int n);
    up_valid = 1'b1; up_sof = 1'b0; up_eol = 1'b0; up_pixel = 24'hDEAD00;
    repeat (n) step();
    up_valid = 1'b0;
  endtask

  task automatic mon_lines(input int n);
    up_valid = 1'b0;
    {mon_valid, mon_ready, mon_last} = 3'b111;
    repeat (n) step();
    {mon_valid, mon_ready, mon_last} = 3'b000;
  endtask

  // Offer pixels 0..npix-1 of a frame; optional stalls, in-frame last beats,
  // a spurious end-of-line at pixel err_k and an abort pulse at pixel abort_k.
  task automatic send_frame(input logic [7:0] t, input int npix, input bit stall,
                            input bit mon_during, input int err_k, input int abort_k);
    bit acc;
    int tries, r, c;
    tag = t;
    for (int k = 0; k < npix; k++) begin
      r = k / W;
      c = k % W;
      up_pixel = {t, 8'(r), 8'(c)};
      up_sof   = (k == 0);
      up_eol   = (c == W - 1) || (k == err_k);
      tries = 0;
      acc = 0;
      while (!acc && tries < 200) begin
        up_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        sr_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        abort    = (k == abort_k);
        {mon_valid, mon_ready, mon_last} =
          (mon_during && k > 0 && ((k % 4) == 0 || k == npix - 1)) ? 3'b111 : 3'b000;
        tick(acc);
        tries++;
      end
      abort = 1'b0;
      {mon_valid, mon_ready, mon_last} = 3'b000;
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept: pixel %0d got no handshake, expected within 200 cycles", k);
      end else if (k == err_k) begin
        chk("eol_err_next_cycle", 32'(error), 32'd1);
      end
    end
    up_valid = 1'b0; up_sof = 1'b0; up_eol = 1'b0; sr_ready = 1'b1;
  endtask

  initial begin
    int base;
    start = 0; continuous = 0; abort = 0; err_clear = 0;
    up_valid = 0; up_sof = 0; up_eol = 0; up_pixel = '0; sr_ready = 1;
    mon_valid = 0; mon_ready = 0; mon_last = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset state.
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_up_ready", 32'(up_ready), 32'd0);
    chk("rst_sr_valid", 32'(sr_valid), 32'd0);

    // Single frame with leading junk.
    pulse_start();
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    junk(3);
    base = fwd;
    send_frame(8'h01, 32, 1'b0, 1'b0, -1, -1);
    chk("t1_forwarded", 32'(fwd - base), 32'd32);
    mon_lines(8);
    chk("t1_count", 32'(frame_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_error", 32'(error), 32'd0);

    // Continuous, two frames with random stalls.
    do_reset();
    continuous = 1'b1;
    pulse_start();
    base = fwd;
    drain_xfer = 0;
    send_frame(8'h02, 32, 1'b1, 1'b0, -1, -1);
    mon_lines(8);
    send_frame(8'h03, 32, 1'b1, 1'b0, -1, -1);
    mon_lines(8);
    chk("t2_forwarded", 32'(fwd - base), 32'd64);
    chk("t2_drain_xfers", 32'(drain_xfer), 32'd0);
    chk("t2_count", 32'(frame_count), 32'd2);
    chk("t2_busy_sync", 32'(busy), 32'd1);
    chk("t2_sync_ready", 32'(up_ready), 32'd1);
    continuous = 1'b0;

    // Spurious end-of-line at row 1 column 5.
    do_reset();
    pulse_start();
    send_frame(8'h04, 32, 1'b0, 1'b0, 13, -1);
    mon_lines(8);
    chk("t3_count", 32'(frame_count), 32'd1);
    chk("t3_error_sticky", 32'(error), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("t3_error_cleared", 32'(error), 32'd0);

    // Abort during FEED in continuous mode, then abort in SYNC.
    do_reset();
    continuous = 1'b1;
    pulse_start();
    send_frame(8'h05, 32, 1'b0, 1'b0, -1, 10);
    mon_lines(8);
    chk("t4_count", 32'(frame_count), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    pulse_start();
    junk(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_sync_abort_idle", 32'(busy), 32'd0);
    chk("t4_sync_abort_count", 32'(frame_count), 32'd1);
    continuous = 1'b0;

    // Reset mid-frame after 20 pixels; count carried over from above.
    pulse_start();
    send_frame(8'h06, 20, 1'b0, 1'b0, -1, -1);
    up_valid = 1'b1; sr_ready = 1'b1; up_pixel = {8'h06, 8'd2, 8'd4};
    #1;
    chk("t5_pre_reset_valid", 32'(sr_valid), 32'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_up_ready", 32'(up_ready), 32'd0);
    chk("t5_rst_sr_valid", 32'(sr_valid), 32'd0);
    chk("t5_rst_pixel", 32'({sr_red, sr_green, sr_blue}), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_count", 32'(frame_count), 32'd0);
    up_valid = 1'b0;
    step();
    rst_n = 1'b1;
    pulse_start();
    send_frame(8'h07, 32, 1'b0, 1'b0, -1, -1);
    mon_lines(8);
    chk("t5_count", 32'(frame_count), 32'd1);
    chk("t5_error", 32'(error), 32'd0);

    // Last output line coincides with the last input pixel; then a stray last in IDLE.
    do_reset();
    pulse_start();
    send_frame(8'h08, 32, 1'b0, 1'b1, -1, -1);
    chk("t6_count_direct", 32'(frame_count), 32'd1);
    chk("t6_no_drain", 32'(busy), 32'd0);
    chk("t6_error_before", 32'(error), 32'd0);
    mon_lines(1);
    chk("t6_idle_last_error", 32'(error), 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
